// File: rtl/mvau_weight_mem_banked_pkg.sv
// Shared MVAU weight-memory types: FSM state encoding and
// helpers for constants derived from the array geometry.
package mvau_weight_mem_banked_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_READY = 2'd2
   } state_t;

   function automatic int bank_bw(input int simd, input int tw);
      return simd * tw;
   endfunction

   function automatic int load_total(input int pe, input int depth);
      return pe * depth;
   endfunction

endpackage

// File: rtl/mvau_wmem_bank.sv
// One PE weight bank: simple-dual-port RAM with a registered read.
// Only the read register is reset; the array itself is never cleared.
module mvau_wmem_bank #(
   parameter int DEPTH   = 4,
   parameter int WIDTH   = 8,
   parameter int ADDR_BW = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic [ADDR_BW-1:0] wr_addr,
   input  logic [WIDTH-1:0]   wr_data,
   input  logic               rd_en,
   input  logic [ADDR_BW-1:0] rd_addr,
   output logic [WIDTH-1:0]   rd_data
);

   (* ram_style = "auto" *) logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst)
         rd_data <= '0;
      else if (rd_en)
         rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/mvau_weight_mem_banked.sv
// Banked MVAU weight memory: streamed reload into PE banks,
// parallel pipelined reads of one word per bank.
module mvau_weight_mem_banked
   import mvau_weight_mem_banked_pkg::*;
#(
   parameter int PE           = 2,
   parameter int SIMD         = 2,
   parameter int TW           = 4,
   parameter int WMEM_DEPTH   = 4,
   parameter int WMEM_ADDR_BW = 4,
   parameter int RD_LAT       = 1
) (
   input  logic                     aclk,
   input  logic                     rst,
   input  logic                     load_start,
   input  logic [SIMD*TW-1:0]       wld_data,
   input  logic                     wld_valid,
   output logic                     wld_ready,
   output logic                     load_done,
   output logic                     busy,
   input  logic                     rd_en,
   input  logic [WMEM_ADDR_BW-1:0]  rd_addr,
   output logic [PE*SIMD*TW-1:0]    rd_data,
   output logic                     rd_valid,
   output logic                     rd_err
);

   localparam int WW    = bank_bw(SIMD, TW);
   localparam int LOADS = load_total(PE, WMEM_DEPTH);
   localparam int PBW   = (PE > 1) ? $clog2(PE) : 1;
   localparam int IW    = (WMEM_DEPTH > 1) ? $clog2(WMEM_DEPTH) : 1;

   state_t state, state_nx;

   logic [PBW-1:0]          pe_cnt;
   logic [WMEM_ADDR_BW-1:0] addr_cnt;
   logic                    accept;
   logic                    last;
   logic                    start;
   logic                    issue;
   logic                    oor;
   logic                    v1;
   logic                    e1;
   logic [PE*WW-1:0]        bank_q;
   logic [PE*WW-1:0]        masked;

   assign wld_ready = (state == S_LOAD);
   assign busy      = (state == S_LOAD);
   assign accept    = wld_valid & wld_ready;
   assign last      = accept &&
      (int'(addr_cnt) * PE + int'(pe_cnt) == LOADS - 1);
   assign start     = load_start & (state != S_LOAD);
   assign issue     = rd_en & (state == S_READY);
   assign oor       = int'(rd_addr) >= WMEM_DEPTH;

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:  if (load_start) state_nx = S_LOAD;
         S_LOAD:  if (last)       state_nx = S_READY;
         S_READY: if (load_start) state_nx = S_LOAD;
         default:                 state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   // word k lands in bank k mod PE at address k div PE
   always_ff @(posedge aclk) begin
      if (rst || start) begin
         pe_cnt   <= '0;
         addr_cnt <= '0;
      end else if (accept) begin
         if (pe_cnt == PBW'(PE - 1)) begin
            pe_cnt   <= '0;
            addr_cnt <= addr_cnt + 1'b1;
         end else begin
            pe_cnt <= pe_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (rst)
         load_done <= 1'b0;
      else
         load_done <= last;
   end

   for (genvar p = 0; p < PE; p++) begin : g_bank
      mvau_wmem_bank #(
         .DEPTH   (WMEM_DEPTH),
         .WIDTH   (WW),
         .ADDR_BW (IW)
      ) u_bank (
         .clk     (aclk),
         .rst     (rst),
         .wr_en   (accept && (pe_cnt == PBW'(p))),
         .wr_addr (addr_cnt[IW-1:0]),
         .wr_data (wld_data),
         .rd_en   (issue & ~oor),
         .rd_addr (rd_addr[IW-1:0]),
         .rd_data (bank_q[p*WW +: WW])
      );
   end

   // e1 only moves on an issued read so masked data holds between beats
   always_ff @(posedge aclk) begin
      if (rst) begin
         v1 <= 1'b0;
         e1 <= 1'b0;
      end else begin
         v1 <= issue;
         if (issue)
            e1 <= oor;
      end
   end

   assign masked = e1 ? '0 : bank_q;

   if (RD_LAT == 1) begin : g_lat1
      assign rd_valid = v1;
      assign rd_err   = v1 & e1;
      assign rd_data  = masked;
   end else begin : g_lat2
      logic             v2;
      logic             e2;
      logic [PE*WW-1:0] d2;

      always_ff @(posedge aclk) begin
         if (rst) begin
            v2 <= 1'b0;
            e2 <= 1'b0;
            d2 <= '0;
         end else begin
            v2 <= v1;
            if (v1) begin
               e2 <= e1;
               d2 <= masked;
            end
         end
      end

      assign rd_valid = v2;
      assign rd_err   = v2 & e2;
      assign rd_data  = d2;
   end

endmodule

// File: tb/tb_mvau_weight_mem_banked.sv
// Scoreboard bench: RD_LAT=1 and RD_LAT=2 instances share stimulus,
// checked against an array image of the expected bank contents.
module tb_mvau_weight_mem_banked;

   localparam int PE    = 2;
   localparam int SIMD  = 2;
   localparam int TW    = 4;
   localparam int DEPTH = 4;
   localparam int ABW   = 4;
   localparam int WW    = SIMD * TW;
   localparam int DW    = PE * WW;
   localparam int NW    = PE * DEPTH;

   logic aclk = 1'b0;
   always #5 aclk = ~aclk;

   logic           rst        = 1'b1;
   logic           load_start = 1'b0;
   logic [WW-1:0]  wld_data   = '0;
   logic           wld_valid  = 1'b0;
   logic           rd_en      = 1'b0;
   logic [ABW-1:0] rd_addr    = '0;

   logic          wld_ready1, load_done1, busy1, rd_valid1, rd_err1;
   logic [DW-1:0] rd_data1;
   logic          wld_ready2, load_done2, busy2, rd_valid2, rd_err2;
   logic [DW-1:0] rd_data2;

   mvau_weight_mem_banked #(
      .PE(PE), .SIMD(SIMD), .TW(TW), .WMEM_DEPTH(DEPTH),
      .WMEM_ADDR_BW(ABW), .RD_LAT(1)
   ) u_dut1 (
      .aclk(aclk), .rst(rst), .load_start(load_start),
      .wld_data(wld_data), .wld_valid(wld_valid),
      .wld_ready(wld_ready1), .load_done(load_done1), .busy(busy1),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
      .rd_valid(rd_valid1), .rd_err(rd_err1)
   );

   mvau_weight_mem_banked #(
      .PE(PE), .SIMD(SIMD), .TW(TW), .WMEM_DEPTH(DEPTH),
      .WMEM_ADDR_BW(ABW), .RD_LAT(2)
   ) u_dut2 (
      .aclk(aclk), .rst(rst), .load_start(load_start),
      .wld_data(wld_data), .wld_valid(wld_valid),
      .wld_ready(wld_ready2), .load_done(load_done2), .busy(busy2),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data2),
      .rd_valid(rd_valid2), .rd_err(rd_err2)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always @(posedge aclk) cyc <= cyc + 1;

   typedef struct {
      logic [DW-1:0] d;
      logic          e;
      int            c;
   } exp_t;

   exp_t q1[$];
   exp_t q2[$];

   logic [WW-1:0] img [PE][DEPTH];
   bit            ready_m = 1'b0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   function automatic logic [DW-1:0] model_word(input int a);
      logic [DW-1:0] r;
      r = '0;
      for (int p = 0; p < PE; p++)
         r[p*WW +: WW] = img[p][a];
      return r;
   endfunction

   task automatic push_read(input logic [DW-1:0] d, input logic e);
      exp_t x;
      x.d = d;
      x.e = e;
      x.c = cyc + 1;
      q1.push_back(x);
      x.c = cyc + 2;
      q2.push_back(x);
   endtask

   task automatic issue(input int a);
      rd_en   = 1'b1;
      rd_addr = ABW'(a);
      if (ready_m) begin
         if (a < DEPTH)
            push_read(model_word(a), 1'b0);
         else
            push_read('0, 1'b1);
      end
   endtask

   task automatic issue_exp(input int a, input logic [DW-1:0] d,
                            input logic e);
      rd_en   = 1'b1;
      rd_addr = ABW'(a);
      push_read(d, e);
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      load_start = 1'b0;
      wld_valid  = 1'b0;
      rd_en      = 1'b0;
      step();
      chk("rst_wld_ready1", wld_ready1, 0);
      chk("rst_busy1", busy1, 0);
      chk("rst_load_done1", load_done1, 0);
      chk("rst_rd_valid1", rd_valid1, 0);
      chk("rst_rd_err1", rd_err1, 0);
      chk("rst_rd_data1", rd_data1, 0);
      chk("rst_busy2", busy2, 0);
      chk("rst_rd_valid2", rd_valid2, 0);
      chk("rst_rd_data2", rd_data2, 0);
      rst     = 1'b0;
      ready_m = 1'b0;
   endtask

   // mode 0: continuous valid, 1: 1,0,0 pattern, 2: random
   task automatic do_load(input int base, input int mode,
                          input int abort_at, input bit with_read);
      logic [WW-1:0] nimg [PE][DEPTH];
      int k;
      int i;
      k = 0;
      i = 0;
      load_start = 1'b1;
      rd_en      = 1'b0;
      if (with_read)
         issue($urandom_range(0, 7));
      step();
      load_start = 1'b0;
      ready_m    = 1'b0;
      while (k < NW) begin
         chk("load_busy1", busy1, 1);
         chk("load_busy2", busy2, 1);
         chk("load_wld_ready1", wld_ready1, 1);
         if (mode == 0)
            wld_valid = 1'b1;
         else if (mode == 1)
            wld_valid = (i % 3 == 0);
         else
            wld_valid = 1'($urandom_range(0, 1));
         wld_data   = WW'(base + k);
         rd_en      = 1'($urandom_range(0, 1));
         rd_addr    = ABW'($urandom);
         load_start = (i == 2);
         if (wld_valid) begin
            nimg[k % PE][k / PE] = wld_data;
            k++;
         end
         i++;
         step();
         if (abort_at >= 0 && k == abort_at) begin
            do_reset();
            return;
         end
      end
      wld_valid  = 1'b0;
      rd_en      = 1'b0;
      load_start = 1'b0;
      chk("load_done1", load_done1, 1);
      chk("load_done2", load_done2, 1);
      chk("done_busy1", busy1, 0);
      chk("done_wld_ready1", wld_ready1, 0);
      img     = nimg;
      ready_m = 1'b1;
      step();
      chk("load_done1_pulse", load_done1, 0);
   endtask

   task automatic rand_reads(input int n);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 3) != 0)
            issue($urandom_range(0, 7));
         else
            rd_en = 1'b0;
         step();
      end
      rd_en = 1'b0;
   endtask

   task automatic mon_one(input int lat, input logic v, input logic e,
                          input logic [DW-1:0] d);
      exp_t x;
      if (!v) begin
         if (e)
            chk(lat == 1 ? "rd_err_idle1" : "rd_err_idle2", e, 0);
      end else if ((lat == 1 ? q1.size() : q2.size()) == 0) begin
         chk(lat == 1 ? "rd_valid_unexp1" : "rd_valid_unexp2", v, 0);
      end else begin
         x = (lat == 1) ? q1.pop_front() : q2.pop_front();
         chk(lat == 1 ? "rd_data1" : "rd_data2", d, x.d);
         chk(lat == 1 ? "rd_err1" : "rd_err2", e, x.e);
         chk(lat == 1 ? "rd_lat1" : "rd_lat2", cyc, x.c);
      end
   endtask

   always @(negedge aclk) begin
      if (rst === 1'b0) begin
         mon_one(1, rd_valid1, rd_err1, rd_data1);
         mon_one(2, rd_valid2, rd_err2, rd_data2);
      end
   end

   initial begin
      step();
      step();
      do_reset();
      rand_reads(8);

      do_load(8'h00, 0, -1, 1'b0);
      issue_exp(2, 16'h0504, 1'b0);
      step();
      issue_exp(5, 16'h0000, 1'b1);
      step();
      rd_en = 1'b0;
      step();
      issue_exp(0, 16'h0100, 1'b0);
      step();
      issue_exp(1, 16'h0302, 1'b0);
      step();
      issue_exp(2, 16'h0504, 1'b0);
      step();
      issue_exp(3, 16'h0706, 1'b0);
      step();
      rd_en = 1'b0;
      rand_reads(30);

      do_load(8'h00, 1, -1, 1'b1);
      issue_exp(1, 16'h0302, 1'b0);
      step();
      issue_exp(3, 16'h0706, 1'b0);
      step();
      rand_reads(20);

      do_load(8'h30, 2, -1, 1'b1);
      rand_reads(30);

      rd_en = 1'b0;
      step();
      step();
      do_load(8'h40, 0, 3, 1'b0);
      rand_reads(8);
      do_load(8'h10, 0, -1, 1'b0);
      issue_exp(3, 16'h1716, 1'b0);
      step();
      rand_reads(30);

      repeat (5) step();
      chk("q1_drained", q1.size(), 0);
      chk("q2_drained", q2.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mvau_weight_mem_banked.md
MVAU_WEIGHT_MEM_BANKED -- requirements
Module: mvau_weight_mem_banked

Interface
REQ-001 SHALL have parameter PE, default 2, meaning the number of processing-element banks.
REQ-002 SHALL have parameter SIMD, default 2, meaning the number of weights per bank word.
REQ-003 SHALL have parameter TW, default 4, meaning the weight bit width.
REQ-004 SHALL have parameter WMEM_DEPTH, default 4, meaning the words per bank.
REQ-005 SHALL have parameter WMEM_ADDR_BW, default 4, meaning the address width; it SHALL satisfy 2^WMEM_ADDR_BW >= WMEM_DEPTH.
REQ-006 SHALL have parameter RD_LAT, default 1, meaning the read latency; legal values are 1 and 2.
REQ-007 SHALL have port aclk, input, width 1: single clock, all logic on its rising edge.
REQ-008 SHALL have port rst, input, width 1: reset, synchronous and active-high.
REQ-009 SHALL have port load_start, input, width 1: single-cycle request to begin a full weight reload.
REQ-010 SHALL have port wld_data, input, width SIMD*TW: load stream word.
REQ-011 SHALL have port wld_valid, input, width 1: load word valid.
REQ-012 SHALL have port wld_ready, output, width 1: load word accepted when wld_valid and wld_ready are both high.
REQ-013 SHALL have port load_done, output, width 1: one-cycle pulse after the last load word.
REQ-014 SHALL have port busy, output, width 1: high while in LOAD.
REQ-015 SHALL have port rd_en, input, width 1: read request.
REQ-016 SHALL have port rd_addr, input, width WMEM_ADDR_BW: read address, common to all banks.
REQ-017 SHALL have port rd_data, output, width PE*SIMD*TW: bank p occupies bits [(p+1)*SIMD*TW-1 : p*SIMD*TW].
REQ-018 SHALL have port rd_valid, output, width 1: rd_data qualifier.
REQ-019 SHALL have port rd_err, output, width 1: out-of-range flag, aligned with rd_valid.

Function
REQ-020 SHALL implement the FSM states IDLE, LOAD and READY; transitions: IDLE->LOAD on load_start; READY->LOAD on load_start; LOAD->READY on acceptance of word PE*WMEM_DEPTH-1.
REQ-021 SHALL ignore load_start while in LOAD.
REQ-022 SHALL drive wld_ready = 1 only in LOAD (combinational from state).
REQ-023 SHALL write the k-th accepted load word (k from 0) to bank (k mod PE) at address (k div PE), using a PE counter that wraps to 0 and increments the address counter.
REQ-024 SHALL clear both load counters on entry to LOAD.
REQ-025 SHALL tolerate wld_valid gaps without skipping addresses.
REQ-026 SHALL pulse load_done on the cycle after the final accepted word, coincident with the first cycle in READY.
REQ-027 SHALL honour rd_en only in READY; in IDLE or LOAD, rd_en SHALL produce no rd_valid.
REQ-028 SHALL, for a read issued at cycle t, assert rd_valid at t+RD_LAT with all PE bank words read in parallel.
REQ-029 SHALL fully pipeline reads: back-to-back rd_en gives back-to-back rd_valid.
REQ-030 SHALL, when rd_addr >= WMEM_DEPTH, return rd_data = 0 and assert rd_err with rd_valid.
REQ-031 SHALL, if load_start and rd_en are asserted in the same READY cycle, complete that read and accept no further reads.
REQ-032 SHALL, for reads in flight when LOAD is entered, still deliver them with their pre-load data.
REQ-033 SHALL hold rd_data between valid beats; rd_data is only meaningful when rd_valid = 1.

Reset
REQ-034 SHALL, on rst, enter IDLE and force wld_ready = 0, load_done = 0, busy = 0, rd_valid = 0, rd_err = 0, rd_data = 0, load counters = 0 and the read pipeline empty.
REQ-035 SHALL, on rst during LOAD, abort the load; memory contents are undefined until the next completed load.
REQ-036 SHALL NOT reset or clear the memory arrays.

Structure
REQ-037 SHALL place the FSM state enum and the derived constants (bank word width, total load count) in the shared MVAU package.
REQ-038 SHALL use one sub-module, mvau_wmem_bank: a simple-dual-port RAM of depth WMEM_DEPTH and width SIMD*TW with a registered read and ram_style "auto", instantiated PE times via generate.

Verification (PE=2, SIMD=2, TW=4, WMEM_DEPTH=4, RD_LAT=1 unless stated)
REQ-039 SHALL cover: load words 0x00..0x07 with continuous valid -> bank0 = {00,02,04,06}, bank1 = {01,03,05,07}; load_done one cycle after word 7.
REQ-040 SHALL cover: after that load, rd_en with rd_addr=2 -> next cycle rd_valid=1, rd_data=0x0504, rd_err=0.
REQ-041 SHALL cover: rd_addr=5 in READY -> rd_valid=1, rd_data=0, rd_err=1.
REQ-042 SHALL cover: wld_valid toggled 1,0,0,1,... during load -> same memory image as REQ-039; busy held high throughout the load.
REQ-043 SHALL cover: rst asserted after 3 words, then a full reload of 0x10..0x17 -> bank1 addr3 = 0x17; no rd_valid seen before load_done.
REQ-044 SHALL cover: RD_LAT=2 with rd_en on addresses 0,1,2,3 back-to-back -> rd_valid high for 4 consecutive cycles starting 2 cycles after the first rd_en, data in issue order.
